// File: rtl/gpu_core_pkg.sv
// Shared TinyGPU core definitions: core FSM encoding, NZP bit positions and
// default widths.
package gpu_core_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;

  localparam int NZP_N_BIT = 2;
  localparam int NZP_Z_BIT = 1;
  localparam int NZP_P_BIT = 0;

  localparam int PC_WIDTH_DEF   = 8;
  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/PC_MuxOne.sv
// Final next-PC select: branch target when the condition holds, else PC+1.
module PC_MuxOne #(
  parameter int WIDTH = 8
) (
  input  logic             NZPSelect,
  input  logic [WIDTH-1:0] CurrentPCPlus,
  input  logic [WIDTH-1:0] Immediate,
  output logic [WIDTH-1:0] Branch
);

  assign Branch = NZPSelect ? Immediate : CurrentPCPlus;

endmodule

// File: rtl/pc_nzp_unit.sv
// Per-thread PC / condition-code stage: holds NZP, resolves BRnzp in EXECUTE,
// and registers NextPC, BranchTaken and the sticky Done flag.
module pc_nzp_unit
  import gpu_core_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [2:0]            CoreState,
  input  logic [PC_WIDTH-1:0]   CurrentPC,
  input  logic [2:0]            DecodedNZP,
  input  logic [PC_WIDTH-1:0]   DecodedImmediate,
  input  logic                  DecodedPCMux,
  input  logic                  DecodedNZPWriteEnable,
  input  logic                  DecodedRet,
  input  logic [DATA_WIDTH-1:0] ALUOut,
  output logic [PC_WIDTH-1:0]   NextPC,
  output logic                  NextPCValid,
  output logic                  BranchTaken,
  output logic [2:0]            NZP,
  output logic                  Done
);

  core_state_t         state;
  logic [2:0]          nzp_p1;
  logic [PC_WIDTH-1:0] nextpc_p1;
  logic                vld_p1;
  logic                taken_p1;
  logic                done_p1;
  logic                nzpsel_p0;
  logic [PC_WIDTH-1:0] pcplus_p0;
  logic [PC_WIDTH-1:0] branch_p0;
  logic                unused_alu_hi;

  assign state         = core_state_t'(CoreState);
  assign unused_alu_hi = ^ALUOut[DATA_WIDTH-1:3];

  // p0: condition evaluation from the registered NZP (no forwarding)
  assign nzpsel_p0 = DecodedPCMux & (|(nzp_p1 & DecodedNZP));
  assign pcplus_p0 = CurrentPC + PC_WIDTH'(1);

  PC_MuxOne #(
    .WIDTH(PC_WIDTH)
  ) u_pc_mux (
    .NZPSelect    (nzpsel_p0),
    .CurrentPCPlus(pcplus_p0),
    .Immediate    (DecodedImmediate),
    .Branch       (branch_p0)
  );

  // p1: architectural registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      nzp_p1    <= 3'b000;
      nextpc_p1 <= '0;
      vld_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      taken_p1 <= 1'b0;
      if (Enable) begin
        if (state == FETCH) begin
          vld_p1 <= 1'b0;
        end else if (!done_p1 && state == EXECUTE) begin
          if (DecodedRet) begin
            done_p1 <= 1'b1;
          end else begin
            nextpc_p1 <= branch_p0;
            vld_p1    <= 1'b1;
            taken_p1  <= nzpsel_p0;
          end
        end else if (!done_p1 && state == UPDATE && DecodedNZPWriteEnable) begin
          nzp_p1 <= ALUOut[2:0];
        end
      end
    end
  end

  assign NextPC      = nextpc_p1;
  assign NextPCValid = vld_p1;
  assign BranchTaken = taken_p1;
  assign NZP         = nzp_p1;
  assign Done        = done_p1;

endmodule

// File: tb/tb_pc_nzp_unit.sv
// Directed and randomized bench for pc_nzp_unit against a rule-level model.
module tb_pc_nzp_unit;
  import gpu_core_pkg::*;

  localparam int PW = 8;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Reset, Enable;
  logic [2:0]    CoreState;
  logic [PW-1:0] CurrentPC;
  logic [2:0]    DecodedNZP;
  logic [PW-1:0] DecodedImmediate;
  logic          DecodedPCMux, DecodedNZPWriteEnable, DecodedRet;
  logic [DW-1:0] ALUOut;
  logic [PW-1:0] NextPC;
  logic          NextPCValid, BranchTaken, Done;
  logic [2:0]    NZP;

  int n_vec  = 0;
  int n_miss = 0;

  // reference state
  int m_nzp, m_pc, m_vld, m_bt, m_done;

  pc_nzp_unit #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .CoreState(CoreState),
    .CurrentPC(CurrentPC), .DecodedNZP(DecodedNZP),
    .DecodedImmediate(DecodedImmediate), .DecodedPCMux(DecodedPCMux),
    .DecodedNZPWriteEnable(DecodedNZPWriteEnable), .DecodedRet(DecodedRet),
    .ALUOut(ALUOut), .NextPC(NextPC), .NextPCValid(NextPCValid),
    .BranchTaken(BranchTaken), .NZP(NZP), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input core_state_t st,
                       input int pc, input int mask, input int imm,
                       input logic pcmux, input logic we, input logic ret, input int alu);
    Reset                 = rst;
    Enable                = en;
    CoreState             = st;
    CurrentPC             = PW'(pc);
    DecodedNZP            = 3'(mask);
    DecodedImmediate      = PW'(imm);
    DecodedPCMux          = pcmux;
    DecodedNZPWriteEnable = we;
    DecodedRet            = ret;
    ALUOut                = DW'(alu);
  endtask

  // Apply the rules of the stage to the inputs present at this edge.
  task automatic model_edge();
    int pc_plus;
    bit taken;
    if (Reset) begin
      m_nzp = 0; m_pc = 0; m_vld = 0; m_bt = 0; m_done = 0;
    end else begin
      m_bt = 0;
      if (Enable) begin
        if (CoreState == FETCH) m_vld = 0;
        else if (m_done == 0 && CoreState == EXECUTE) begin
          if (DecodedRet) m_done = 1;
          else begin
            pc_plus = (int'(CurrentPC) + 1) % (1 << PW);
            taken   = DecodedPCMux && ((m_nzp & int'(DecodedNZP)) != 0);
            m_pc    = taken ? int'(DecodedImmediate) : pc_plus;
            m_vld   = 1;
            m_bt    = taken ? 1 : 0;
          end
        end else if (m_done == 0 && CoreState == UPDATE && DecodedNZPWriteEnable)
          m_nzp = int'(ALUOut) % 8;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    chk({tag, ".NextPC"},      32'(NextPC),      32'(m_pc));
    chk({tag, ".NextPCValid"}, 32'(NextPCValid), 32'(m_vld));
    chk({tag, ".BranchTaken"}, 32'(BranchTaken), 32'(m_bt));
    chk({tag, ".NZP"},         32'(NZP),         32'(m_nzp));
    chk({tag, ".Done"},        32'(Done),        32'(m_done));
  endtask

  initial begin
    drive(1, 1, EXECUTE, 8'hAB, 3'b111, 8'h77, 1, 1, 1, 8'hFF);
    tick("reset");
    chk("reset_pc_const", 32'(NextPC), 32'h0);
    chk("reset_done_const", 32'(Done), 32'h0);

    drive(0, 1, EXECUTE, 8'h10, 3'b000, 8'h99, 0, 0, 0, 0);
    tick("pc_plus1");
    chk("pc_plus1_const", 32'(NextPC), 32'h11);
    drive(0, 1, EXECUTE, 8'hFF, 3'b000, 8'h99, 0, 0, 0, 0);
    tick("pc_wrap");
    chk("pc_wrap_const", 32'(NextPC), 32'h00);
    drive(0, 1, FETCH, 0, 0, 0, 0, 0, 0, 0);
    tick("fetch_clears_valid");
    chk("fetch_valid_const", 32'(NextPCValid), 32'h0);

    drive(0, 1, UPDATE, 0, 0, 0, 0, 1, 0, 8'h02);
    tick("cmp_z");
    chk("cmp_z_const", 32'(NZP), 32'h2);
    drive(0, 1, EXECUTE, 8'h05, 3'b010, 8'h40, 1, 0, 0, 0);
    tick("brz_taken");
    chk("brz_pc_const", 32'(NextPC), 32'h40);
    chk("brz_pulse_const", 32'(BranchTaken), 32'h1);
    drive(0, 1, DECODE, 8'h05, 3'b010, 8'h40, 1, 0, 0, 0);
    tick("pulse_ends");
    drive(0, 1, EXECUTE, 8'h05, 3'b100, 8'h40, 1, 0, 0, 0);
    tick("brn_not_taken");
    chk("brn_pc_const", 32'(NextPC), 32'h06);

    drive(0, 0, EXECUTE, 8'h05, 3'b010, 8'h40, 1, 0, 0, 0);
    tick("enable0_exec");
    drive(0, 0, UPDATE, 0, 0, 0, 0, 1, 0, 8'h07);
    tick("enable0_update");
    chk("enable0_nzp_const", 32'(NZP), 32'h2);

    drive(0, 1, UPDATE, 0, 0, 0, 0, 1, 0, 8'h07);
    tick("cmp_multihot");
    drive(0, 1, EXECUTE, 8'h33, 3'b000, 8'h80, 1, 0, 0, 0);
    tick("mask000_never");
    chk("mask000_pc_const", 32'(NextPC), 32'h34);
    drive(0, 1, EXECUTE, 8'h33, 3'b111, 8'h80, 0, 0, 0, 0);
    tick("pcmux0_plus1");
    drive(0, 1, EXECUTE, 8'h60, 3'b010, 8'h50, 1, 1, 0, 8'h04);
    tick("branch_with_we_exec");
    drive(0, 1, UPDATE, 8'h60, 3'b010, 8'h50, 1, 1, 0, 8'h04);
    tick("branch_with_we_update");

    drive(1, 1, EXECUTE, 8'h05, 3'b111, 8'h40, 1, 1, 0, 8'h07);
    tick("reset_beats_branch");

    drive(0, 1, EXECUTE, 8'h40, 3'b000, 0, 0, 0, 0, 0);
    tick("pre_ret");
    drive(0, 1, EXECUTE, 8'h20, 3'b010, 8'h70, 1, 0, 1, 0);
    tick("ret");
    chk("ret_done_const", 32'(Done), 32'h1);
    chk("ret_pc_const", 32'(NextPC), 32'h41);
    drive(0, 1, EXECUTE, 8'h30, 3'b000, 0, 0, 0, 0, 0);
    tick("after_done_exec");
    chk("after_done_pc_const", 32'(NextPC), 32'h41);
    drive(0, 1, UPDATE, 0, 0, 0, 0, 1, 0, 8'h01);
    tick("after_done_update");
    drive(1, 0, IDLE, 0, 0, 0, 0, 0, 0, 0);
    tick("done_cleared_by_reset");

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
            core_state_t'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), int'($urandom_range(0, 255)));
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
